aoc_1_rotation_parser: RTL

AOC_1_ROTATION_PARSER -- requirements
Module: aoc_1_rotation_parser

---
 rtl/aoc_1_rotation_parser.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/aoc_1_rotation_parser.sv
// aoc_1_rotation_parser
// Parses an ASCII stream of rotation lines ("L68\n", "R48\r\n", ...) into
// (direction, distance) pulses for a downstream safe-dial model. Malformed
// lines produce one parse_error pulse each. Distances saturate at
// 2^DIST_W-1.
//
// Optional feature: define AOC_PARSER_STATS_EN to build the saturating
// rotation_count / error_count registers. Without it those ports read 0.
//
// Handshake: a byte transfers on a rising clk edge where byte_valid and
// byte_ready are both high; byte_ready is a combinational function of rst,
// flush and the FSM state, and never depends on byte_valid.
//
// dbg_state_o exposes the FSM state encoding
// (0 IDLE, 1 DIR_SEEN, 2 DIGITS, 3 SKIP, 4 EMIT).
module aoc_1_rotation_parser #(
  parameter int DIST_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              flush,
  output logic              direction,
  output logic [DIST_W-1:0] rotation_distance,
  output logic              valid_rotation,
  output logic              parse_error,
  output logic [DIST_W-1:0] rotation_count,
  output logic [DIST_W-1:0] error_count,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DIR_SEEN = 3'd1,
    DIGITS   = 3'd2,
    SKIP     = 3'd3,
    EMIT     = 3'd4
  } state_t;

  localparam logic [DIST_W-1:0] SAT_MAX = '1;

  state_t            state_q;
  logic              dir_q;      // direction of the line being parsed
  logic [DIST_W-1:0] acc_q;      // decimal accumulator of the current line
  logic [DIST_W-1:0] acc_d;
  logic              flagged_q;  // current SKIP line already reported
  logic              dir_out_q;
  logic [DIST_W-1:0] dist_q;
  logic              valid_q;
  logic              perr_q;

  logic              accept;
  logic              is_lf;
  logic              is_cr;
  logic              is_sp;
  logic              is_dir;
  logic              is_digit;
  logic [DIST_W+3:0] acc_wide;
  logic              go_emit;
  logic              go_err;

  assign byte_ready = !rst && !flush && (state_q != EMIT);
  assign accept     = byte_valid && byte_ready;

  assign is_lf    = (byte_in == 8'h0A);
  assign is_cr    = (byte_in == 8'h0D);
  assign is_sp    = (byte_in == 8'h20);
  assign is_dir   = (byte_in == 8'h4C) || (byte_in == 8'h52);
  assign is_digit = (byte_in >= 8'h30) && (byte_in <= 8'h39);

  // acc*10 + digit computed 4 bits wider so overflow is visible, then clamped.
  assign acc_wide = ({4'b0000, acc_q} << 3) + ({4'b0000, acc_q} << 1)
                  + {{DIST_W{1'b0}}, byte_in[3:0]};
  assign acc_d    = (acc_wide > {4'b0000, SAT_MAX}) ? SAT_MAX : acc_wide[DIST_W-1:0];

  // Decode the cycles that emit a rotation or report a malformed line.
  always_comb begin
    go_emit = 1'b0;
    go_err  = 1'b0;
    case (state_q)
      DIR_SEEN: go_err  = flush || (accept && !is_cr && !is_digit);
      DIGITS: begin
        go_emit = flush || (accept && is_lf);
        go_err  = accept && !is_cr && !is_digit && !is_lf;
      end
      SKIP:     go_err  = !flagged_q && (flush || (accept && is_lf));
      default: begin
        go_emit = 1'b0;
        go_err  = 1'b0;
      end
    endcase
  end

  // Parser FSM with registered rotation outputs and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      dir_q     <= 1'b0;
      acc_q     <= '0;
      flagged_q <= 1'b0;
      dir_out_q <= 1'b0;
      dist_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      valid_q <= go_emit;
      perr_q  <= go_err;
      if (go_emit) begin
        dir_out_q <= dir_q;
        dist_q    <= acc_q;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_dir) begin
              dir_q   <= (byte_in == 8'h52);
              acc_q   <= '0;
              state_q <= DIR_SEEN;
            end else if (!is_lf && !is_cr && !is_sp) begin
              flagged_q <= 1'b0;
              state_q   <= SKIP;
            end
          end
        end
        DIR_SEEN, DIGITS: begin
          if (flush) begin
            state_q <= (state_q == DIGITS) ? EMIT : IDLE;
          end else if (accept && !is_cr) begin
            if (is_digit) begin
              acc_q   <= acc_d;
              state_q <= DIGITS;
            end else if (is_lf) begin
              state_q <= (state_q == DIGITS) ? EMIT : IDLE;
            end else begin
              flagged_q <= 1'b1;
              state_q   <= SKIP;
            end
          end
        end
        SKIP: begin
          if (flush || (accept && is_lf)) begin
            state_q <= IDLE;
          end
        end
        EMIT:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign direction         = dir_out_q;
  assign rotation_distance = dist_q;
  assign valid_rotation    = valid_q;
  assign parse_error       = perr_q;
  assign dbg_state_o       = state_q;

`ifdef AOC_PARSER_STATS_EN
  logic [DIST_W-1:0] rot_cnt_q;
  logic [DIST_W-1:0] err_cnt_q;

  // Saturating counts of emitted rotations and malformed lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rot_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (go_emit && (rot_cnt_q != SAT_MAX)) rot_cnt_q <= rot_cnt_q + DIST_W'(1);
      if (go_err && (err_cnt_q != SAT_MAX))  err_cnt_q <= err_cnt_q + DIST_W'(1);
    end
  end

  assign rotation_count = rot_cnt_q;
  assign error_count    = err_cnt_q;
`else
  assign rotation_count = '0;
  assign error_count    = '0;
`endif

endmodule
